// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump streamer.
// The MEM_DUMP_CHECKSUM_EN build appends an XOR checksum beat at CHECKSUM_ADDR.
package mem_dump_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} dump_state_t;

    localparam int DUMP_ADDR_W   = 5;
    localparam int DUMP_COUNT_W  = 6;
    localparam int CHECKSUM_ADDR = 0;
endpackage

// File: rtl/mem_dump_streamer_stream_out_reg.sv
// Valid/ready output holding register: loads a new payload, holds it under
// backpressure, and clears valid once the last payload is taken.
module stream_out_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 ready,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] held
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            held  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            held  <= payload;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mem_dump_streamer.sv
// Walks an address window of the register memory and streams each word out
// over valid/ready, tagged with its address. Option: MEM_DUMP_CHECKSUM_EN.
module mem_dump_streamer
    import mem_dump_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = DUMP_ADDR_W,
    parameter int COUNT_W = DUMP_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base,
    input  logic [COUNT_W-1:0] count,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [WIDTH-1:0]   rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_last,
    output logic               busy,
    output logic               done
);
    localparam int PW = WIDTH + ADDR_W + 1;

    dump_state_t        state, state_next;
    logic [ADDR_W-1:0]  pointer;
    logic [COUNT_W-1:0] remaining;
    logic               start_ok, can_load, load_data, load_csum, last_load;
    logic               handshake, done_set;
    logic [PW-1:0]      pay_d, pay_q;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0]   csum;
    logic               csum_pend;
`endif

    assign rd_addr   = pointer;
    assign handshake = m_valid && m_ready;
    assign can_load  = !m_valid || m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok)  state_next = STREAM;
            STREAM:  if (last_load) state_next = DRAIN;
            DRAIN:   if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_ok  = 1'b0;
        done_set  = 1'b0;
        load_data = (remaining != '0) && can_load;
`ifdef MEM_DUMP_CHECKSUM_EN
        load_csum = csum_pend && (remaining == '0) && can_load;
        last_load = load_csum;
`else
        load_csum = 1'b0;
        last_load = load_data && (remaining == COUNT_W'(1));
`endif
        case (state)
            IDLE: begin
                start_ok = start && (count != '0);
                done_set = start && (count == '0);
            end
            DRAIN:   done_set = handshake;
            default: ;
        endcase
    end

    always_comb begin
`ifdef MEM_DUMP_CHECKSUM_EN
        // Data beats never carry last; the trailing checksum beat does.
        if (load_csum) pay_d = {csum, ADDR_W'(CHECKSUM_ADDR), 1'b1};
        else           pay_d = {rd_data, pointer, 1'b0};
`else
        pay_d = {rd_data, pointer, remaining == COUNT_W'(1)};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= done_set;
            if (start_ok) begin
                pointer   <= base;
                remaining <= count;
                busy      <= 1'b1;
            end else begin
                if (load_data) begin
                    pointer   <= pointer + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                if (state == DRAIN && handshake) busy <= 1'b0;
            end
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum      <= '0;
            csum_pend <= 1'b0;
        end else if (start_ok) begin
            csum      <= '0;
            csum_pend <= 1'b1;
        end else begin
            if (load_data) csum <= csum ^ rd_data;
            if (load_csum) csum_pend <= 1'b0;
        end
    end
`endif

    stream_out_reg #(.PAYLOAD_W(PW)) u_out (
        .clk     (clk),
        .reset   (reset),
        .load    (load_data || load_csum),
        .ready   (m_ready),
        .payload (pay_d),
        .valid   (m_valid),
        .held    (pay_q)
    );

    assign {m_data, m_addr, m_last} = pay_q;
endmodule

// File: tb/tb_mem_dump_streamer.sv
// Directed and randomized bench for mem_dump_streamer with a queue-based model
// of the expected beat sequence; honours MEM_DUMP_CHECKSUM_EN when defined.
module tb_mem_dump_streamer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base = '0;
    logic [5:0]  count = '0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:31];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    assign rd_data = mem[rd_addr];

    mem_dump_streamer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .base    (base),
        .count   (count),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_addr  (m_addr),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats: consecutive addresses modulo 32, last on the final one.
    task automatic build_expected(input int b, input int n);
        logic [31:0] x;
        beat_t bt;
        exp_q.delete();
        x = 32'h0;
        for (int i = 0; i < n; i++) begin
            bt.addr = 5'((b + i) % 32);
            bt.data = mem[(b + i) % 32];
`ifdef MEM_DUMP_CHECKSUM_EN
            bt.last = 1'b0;
`else
            bt.last = (i == n - 1);
`endif
            x ^= bt.data;
            exp_q.push_back(bt);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (n > 0) begin
            bt.data = x;
            bt.addr = 5'd0;
            bt.last = 1'b1;
            exp_q.push_back(bt);
        end
`endif
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[k % 7];
        return 1'($urandom_range(0, 1));
    endfunction

    // mode: 0 ready held high, 1 fixed toggle pattern, 2 random; poke re-starts mid-dump.
    task automatic run_dump(input int b, input int n, input int mode, input bit poke);
        int k;
        int got;
        int nexp;
        build_expected(b, n);
        nexp = exp_q.size();
        m_ready = ready_for(mode, 0);
        base = 5'(b);
        count = 6'(n);
        start = 1'b1;
        next_edge();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        k = 0;
        got = 0;
        while (got < nexp && k < 400) begin
            @(negedge clk);
            if (k == 0) check("latency_not_yet", 64'(m_valid), 64'd0);
            if (k == 1) check("latency_first", 64'(m_valid), 64'd1);
            if (m_valid) begin
                check("beat_data", 64'(m_data), 64'(exp_q[got].data));
                check("beat_addr", 64'(m_addr), 64'(exp_q[got].addr));
                check("beat_last", 64'(m_last), 64'(exp_q[got].last));
                if (m_ready) got++;
            end
            k++;
            if (got < nexp) begin
                next_edge();
                m_ready = ready_for(mode, k);
                if (poke && k == 2) begin
                    start = 1'b1;
                    base = 5'($urandom_range(0, 31));
                    count = 6'($urandom_range(1, 32));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("beats_accepted", 64'(got), 64'(nexp));
        next_edge();
        check("done_pulse", 64'(done), 64'd1);
        check("busy_cleared", 64'(busy), 64'd0);
        next_edge();
        check("done_one_cycle", 64'(done), 64'd0);
        check("no_extra_beat", 64'(m_valid), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_addr", 64'(m_addr), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        reset = 1'b1;
        next_edge();

        // Basic window, wrap-around, stalled window
        run_dump(2, 3, 0, 1'b0);
        run_dump(30, 4, 0, 1'b0);
        run_dump(30, 4, 1, 1'b0);

        // Empty dump: done pulse only
        count = 6'd0;
        base = 5'd7;
        start = 1'b1;
        next_edge();
        start = 1'b0;
        check("empty_done", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);
        check("empty_valid", 64'(m_valid), 64'd0);
        next_edge();
        check("empty_done_off", 64'(done), 64'd0);
        check("empty_valid_off", 64'(m_valid), 64'd0);

        // Start while busy is ignored
        run_dump(10, 6, 0, 1'b1);

        // Reset mid-dump after two accepted beats
        begin
            int hs;
            int guard;
            m_ready = 1'b1;
            base = 5'd4;
            count = 6'd5;
            start = 1'b1;
            next_edge();
            start = 1'b0;
            hs = 0;
            guard = 0;
            while (hs < 2 && guard < 20) begin
                @(negedge clk);
                if (m_valid && m_ready) hs++;
                guard++;
                @(posedge clk);
            end
            check("abort_reached_two", 64'(hs), 64'd2);
            #2;
            reset = 1'b0;
            #1;
            check("abort_valid", 64'(m_valid), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_rd_addr", 64'(rd_addr), 64'd0);
            @(posedge clk);
            #2;
            reset = 1'b1;
            next_edge();
            check("abort_no_done", 64'(done), 64'd0);
            check("abort_idle_valid", 64'(m_valid), 64'd0);
        end
        run_dump(20, 3, 0, 1'b0);

        // Checksum-style pattern and a full-memory dump
        mem[0] = 32'h1;
        mem[1] = 32'h2;
        mem[2] = 32'h4;
        mem[3] = 32'h8;
        run_dump(0, 4, 0, 1'b0);
        run_dump(0, 32, 2, 1'b0);

        // Randomized windows, contents and backpressure
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            run_dump(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 2, 1'(t % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
